// File: rtl/pipeline_stage_register.sv
// Pipeline stage register with valid/ready handshake and flush.
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer; default is a single-entry stage.
module pipeline_stage_register #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic              push, pop;
    logic              load_head_in;
    logic [CTRL_W-1:0] head_ctrl;
    logic [DATA_W-1:0] head_data;

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_valid = (state != EMPTY);
    // Bubbles carry zero control so downstream write enables stay inhibited.
    assign out_ctrl  = out_valid ? head_ctrl : '0;
    assign out_data  = head_data;

    always_comb begin
        occupancy = 2'd0;
        case (state)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

`ifdef PIPE_STAGE_SKID_EN
    logic              ready_q;
    logic              load_head_skid;
    logic              load_skid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign in_ready = ready_q;

    always_comb begin
        state_nx       = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nx     = ONE;
                    load_head_in = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_head_in = 1'b1;
                end else if (push) begin
                    state_nx  = TWO;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_nx = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_nx       = ONE;
                    load_head_skid = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
        if (flush) begin
            state_nx       = EMPTY;
            load_head_in   = 1'b0;
            load_head_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            ready_q   <= 1'b0;
            head_ctrl <= '0;
            head_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            state   <= state_nx;
            // Registered from the next state so in_ready never depends on out_ready.
            ready_q <= (state_nx != TWO);
            if (load_head_in) begin
                head_ctrl <= in_ctrl;
                head_data <= in_data;
            end else if (load_head_skid) begin
                head_ctrl <= skid_ctrl;
                head_data <= skid_data;
            end
            if (load_skid) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end
        end
    end
`else
    logic ready_en;

    // ready_en keeps in_ready low through reset and for the edge that releases it.
    assign in_ready = ready_en && (!out_valid || out_ready);

    always_comb begin
        state_nx     = state;
        load_head_in = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nx     = ONE;
                    load_head_in = 1'b1;
                end
            end
            ONE: begin
                if (push) begin
                    load_head_in = 1'b1;
                end else if (pop) begin
                    state_nx = EMPTY;
                end
            end
            default: state_nx = EMPTY;
        endcase
        if (flush) begin
            state_nx     = EMPTY;
            load_head_in = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            ready_en  <= 1'b0;
            head_ctrl <= '0;
            head_data <= '0;
        end else begin
            state    <= state_nx;
            ready_en <= 1'b1;
            if (load_head_in) begin
                head_ctrl <= in_ctrl;
                head_data <= in_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Directed self-checking bench for pipeline_stage_register (both PIPE_STAGE_SKID_EN builds).
module tb_pipeline_stage_register;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_ctrl;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ctrl;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    int passed = 0;
    int total  = 0;

    pipeline_stage_register #(
        .DATA_W(32),
        .CTRL_W(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [15:0] c);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 32'h99, 16'hFFFF);
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_ctrl", {16'd0, out_ctrl}, 32'd0);
        chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);

        rst = 1'b1;
        drive(1'b0, 32'h0, 16'h0);
        #1 chk("rel_in_ready_low", {31'd0, in_ready}, 32'd0);
        tick();
        chk("rel_in_ready_high", {31'd0, in_ready}, 32'd1);

        out_ready = 1'b1;
        drive(1'b1, 32'h11, 16'h0011);
        tick();
        chk("str_valid_11", {31'd0, out_valid}, 32'd1);
        chk("str_data_11", out_data, 32'h11);
        chk("str_occ_11", {30'd0, occupancy}, 32'd1);
        drive(1'b1, 32'h22, 16'h0022);
        tick();
        chk("str_data_22", out_data, 32'h22);
        chk("str_occ_22", {30'd0, occupancy}, 32'd1);
        drive(1'b1, 32'h33, 16'hFFFF);
        tick();
        chk("str_data_33", out_data, 32'h33);
        chk("str_ctrl_33", {16'd0, out_ctrl}, 32'hFFFF);
        chk("str_occ_33", {30'd0, occupancy}, 32'd1);
        drive(1'b0, 32'h0, 16'h0);
        tick();
        chk("bub_valid", {31'd0, out_valid}, 32'd0);
        chk("bub_ctrl", {16'd0, out_ctrl}, 32'd0);
        chk("bub_data_hold", out_data, 32'h33);
        chk("bub_occ", {30'd0, occupancy}, 32'd0);

`ifdef PIPE_STAGE_SKID_EN
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 16'h000A);
        tick();
        chk("bp_occ1", {30'd0, occupancy}, 32'd1);
        chk("bp_data_a", out_data, 32'hA);
        chk("bp_ready1", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 32'hB, 16'h000B);
        tick();
        chk("bp_occ2", {30'd0, occupancy}, 32'd2);
        chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
        chk("bp_data_hold_a", out_data, 32'hA);
        drive(1'b0, 32'h0, 16'h0);
        out_ready = 1'b1;
        tick();
        chk("bp_data_b", out_data, 32'hB);
        chk("bp_ctrl_b", {16'd0, out_ctrl}, 32'h000B);
        chk("bp_occ_pop", {30'd0, occupancy}, 32'd1);
        chk("bp_ready_pop", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_empty", {30'd0, occupancy}, 32'd0);

        out_ready = 1'b0;
        drive(1'b1, 32'h1, 16'h0001);
        tick();
        drive(1'b1, 32'h2, 16'h0002);
        tick();
        chk("fl_occ_full", {30'd0, occupancy}, 32'd2);
        flush = 1'b1;
        drive(1'b1, 32'hC, 16'h000C);
        tick();
        chk("fl_occ", {30'd0, occupancy}, 32'd0);
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_ctrl", {16'd0, out_ctrl}, 32'd0);
        chk("fl_ready", {31'd0, in_ready}, 32'd1);
        flush = 1'b0;
        drive(1'b0, 32'h0, 16'h0);
        out_ready = 1'b1;
        tick();
        chk("fl_no_c", {31'd0, out_valid}, 32'd0);
`else
        out_ready = 1'b0;
        drive(1'b1, 32'h4, 16'h0004);
        tick();
        chk("ns_data_4", out_data, 32'h4);
        chk("ns_occ_4", {30'd0, occupancy}, 32'd1);
        drive(1'b1, 32'h6, 16'h0006);
        #1 chk("ns_ready_stall", {31'd0, in_ready}, 32'd0);
        tick();
        chk("ns_hold_4", out_data, 32'h4);
        chk("ns_occ_stall", {30'd0, occupancy}, 32'd1);
        out_ready = 1'b1;
        drive(1'b1, 32'h5, 16'h0005);
        #1 chk("ns_ready_pass", {31'd0, in_ready}, 32'd1);
        tick();
        chk("ns_data_5", out_data, 32'h5);
        chk("ns_occ_5", {30'd0, occupancy}, 32'd1);
        flush = 1'b1;
        drive(1'b1, 32'hC, 16'h000C);
        tick();
        chk("fl_occ", {30'd0, occupancy}, 32'd0);
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_ctrl", {16'd0, out_ctrl}, 32'd0);
        chk("fl_data_hold", out_data, 32'h5);
        flush = 1'b0;
        drive(1'b0, 32'h0, 16'h0);
        tick();
        chk("fl_no_c", {31'd0, out_valid}, 32'd0);
`endif

        out_ready = 1'b0;
        drive(1'b1, 32'h77, 16'h0077);
        tick();
        chk("mr_valid_pre", {31'd0, out_valid}, 32'd1);
        drive(1'b0, 32'h0, 16'h0);
        rst = 1'b0;
        #1;
        chk("mr_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_occ", {30'd0, occupancy}, 32'd0);
        chk("mr_data", out_data, 32'd0);
        chk("mr_ready", {31'd0, in_ready}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("mr_ready_rel", {31'd0, in_ready}, 32'd1);
        chk("mr_valid_rel", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
